// File: rtl/idl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : idl_pkg
// Brief    : Shared encodings for the input data latch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package idl_pkg;

    // Sequencer state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_DRIVE = 2'd2;

    // Fetch destination codes as presented on the dest input
    typedef logic [1:0] dest_t;
    localparam dest_t DEST_DB   = 2'b00;
    localparam dest_t DEST_ADL  = 2'b01;
    localparam dest_t DEST_ADH  = 2'b10;
    localparam dest_t DEST_PAIR = 2'b11;

endpackage : idl_pkg
`default_nettype wire

// File: rtl/idl_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : idl_wait_timer
// Brief    : Wait-state counter with clear/enable and a terminal count flag
//            that rises when the count reaches WAIT_MAX-1.
// Revision : 1.0 - initial release
// ============================================================================
module idl_wait_timer #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] c_TC  = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    // Count wait cycles; clear has priority over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign tc = (r_cnt == c_TC);

endmodule : idl_wait_timer
`default_nettype wire

// File: rtl/idl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : idl_sequencer
// Brief    : Turns fetch requests into input data latch control pulses
//            (wa/oadb/oaal/oaah), handling memory wait-states, consumer
//            stalls and the ADL-then-ADH pair fetch.
// Revision : 1.0 - initial release
// ============================================================================
module idl_sequencer
    import idl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [1:0] dest,
    input  logic       mem_rdy,
    input  logic       hold,
    output logic       wa,
    output logic       oadb,
    output logic       oaal,
    output logic       oaah,
    output logic       ack,
    output logic       done,
    output logic       err,
    output logic       busy
);

    state_t r_state;
    state_t w_state_nxt;
    dest_t  r_tgt;
    dest_t  w_tgt_nxt;
    logic   r_pair;
    logic   w_pair_nxt;
    logic   r_armed;
    logic   w_tmr_clr;
    logic   w_tmr_en;
    logic   w_tmr_tc;
    logic   w_split;
    logic   w_release;
    logic   w_accept;

    idl_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) u_wait_timer (
        .clk (clk),
        .rst (rst),
        .clr (w_tmr_clr),
        .en  (w_tmr_en),
        .tc  (w_tmr_tc)
    );

    // First-half pair drive: the ADH half still has to be fetched
    assign w_split   = r_pair && (r_tgt == DEST_ADL);
    // Final drive cycle of the current request
    assign w_release = (r_state == ST_DRIVE) && !hold && !w_split;
    // New request accepted from IDLE or back-to-back off the final drive;
    // held off for the first cycle after reset release
    assign w_accept  = r_armed && req && ((r_state == ST_IDLE) || w_release);

    // Keeps outputs quiet in the first cycle after reset is released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // State register with latched target and pair flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tgt   <= DEST_DB;
            r_pair  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_pair  <= w_pair_nxt;
        end
    end

    // Next-state, target and wait-timer control
    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_pair_nxt  = r_pair;
        w_tmr_clr   = 1'b0;
        w_tmr_en    = 1'b0;
        if (w_accept) begin
            // A pair request starts with the ADL half
            w_state_nxt = ST_LOAD;
            w_tgt_nxt   = (dest == DEST_PAIR) ? DEST_ADL : dest;
            w_pair_nxt  = (dest == DEST_PAIR);
            w_tmr_clr   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_LOAD: begin
                    if (mem_rdy) begin
                        w_state_nxt = ST_DRIVE;
                    end else if (w_tmr_tc) begin
                        // Timeout abandons the request, including any ADH half
                        w_state_nxt = ST_IDLE;
                        w_pair_nxt  = 1'b0;
                    end else begin
                        w_tmr_en = 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (!hold) begin
                        if (w_split) begin
                            w_state_nxt = ST_LOAD;
                            w_tgt_nxt   = DEST_ADH;
                            w_pair_nxt  = 1'b0;
                            w_tmr_clr   = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_pair_nxt  = 1'b0;
                end
            endcase
        end
    end

    // Output decode; wa follows mem_rdy directly while loading
    always_comb begin
        busy = (r_state != ST_IDLE);
        wa   = (r_state == ST_LOAD) && mem_rdy;
        oadb = (r_state == ST_DRIVE) && (r_tgt == DEST_DB);
        oaal = (r_state == ST_DRIVE) && (r_tgt == DEST_ADL);
        oaah = (r_state == ST_DRIVE) && (r_tgt == DEST_ADH);
        ack  = w_accept;
        done = w_release;
        err  = (r_state == ST_LOAD) && !mem_rdy && w_tmr_tc;
    end

endmodule : idl_sequencer
`default_nettype wire

// File: tb/tb_idl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_idl_sequencer
// Brief    : Self-checking bench for idl_sequencer: a queue-based model of
//            outstanding latch targets, a bench-side latch, directed vectors
//            with literal expectations and per-cycle invariant checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idl_sequencer;

    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;

    logic       clk;
    logic       rst;
    logic       req;
    logic [1:0] dest;
    logic       mem_rdy;
    logic       hold;
    logic       wa, oadb, oaal, oaah, ack, done, err, busy;
    logic [7:0] datain;
    logic [7:0] latch;

    int checks = 0;
    int errors = 0;

    // Model: targets still to serve (0 DB, 1 ADL, 2 ADH), front is current
    int   m_q[$];
    bit   m_busy   = 1'b0;
    bit   m_have   = 1'b0;
    int   m_waited = 0;
    bit   m_armed  = 1'b0;

    // Output vector: {wa, oadb, oaal, oaah, ack, done, err, busy}
    wire [7:0] outs = {wa, oadb, oaal, oaah, ack, done, err, busy};

    idl_sequencer #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .dest    (dest),
        .mem_rdy (mem_rdy),
        .hold    (hold),
        .wa      (wa),
        .oadb    (oadb),
        .oaal    (oaal),
        .oaah    (oaah),
        .ack     (ack),
        .done    (done),
        .err     (err),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic load_targets(input logic [1:0] d);
        m_q.delete();
        if (d == 2'b11) begin
            m_q.push_back(1);
            m_q.push_back(2);
        end else begin
            m_q.push_back(int'(d));
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [7:0] o;
        o = 8'h00;
        if (rst) return o;
        if (!m_busy) begin
            o[3] = m_armed && req;
        end else if (!m_have) begin
            o[0] = 1'b1;
            o[7] = mem_rdy;
            o[1] = !mem_rdy && (m_waited == WAIT_MAX - 1);
        end else begin
            o[0] = 1'b1;
            case (m_q[0])
                0:       o[6] = 1'b1;
                1:       o[5] = 1'b1;
                default: o[4] = 1'b1;
            endcase
            if (!hold && m_q.size() == 1) begin
                o[2] = 1'b1;
                o[3] = req;
            end
        end
        return o;
    endfunction

    // Compare process: check outputs, then advance model and latch. Inputs
    // are stable from just after one rising edge to the next, so values
    // seen here equal those the DUT sees on the coming edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            e = model_out();
            chk("model", outs, e);
            chk("inv_onehot", {7'd0, ($countones({oadb, oaal, oaah}) <= 1)}, 8'd1);
            chk("inv_wa_drv", {7'd0, !(wa && (oadb || oaal || oaah))}, 8'd1);
            chk("inv_ack_err", {7'd0, !(ack && err)}, 8'd1);
            chk("inv_done_drv", {7'd0, !done || (oadb || oaal || oaah)}, 8'd1);
            if (wa) latch = datain;
            if (rst) begin
                m_q.delete();
                m_busy   = 1'b0;
                m_have   = 1'b0;
                m_waited = 0;
                m_armed  = 1'b0;
            end else begin
                if (!m_busy) begin
                    if (e[3]) begin
                        load_targets(dest);
                        m_busy   = 1'b1;
                        m_have   = 1'b0;
                        m_waited = 0;
                    end
                end else if (!m_have) begin
                    if (mem_rdy) begin
                        m_have = 1'b1;
                    end else if (m_waited == WAIT_MAX - 1) begin
                        m_busy = 1'b0;
                        m_q.delete();
                    end else begin
                        m_waited++;
                    end
                end else if (!hold) begin
                    void'(m_q.pop_front());
                    if (m_q.size() > 0) begin
                        m_have   = 1'b0;
                        m_waited = 0;
                    end else if (req) begin
                        load_targets(dest);
                        m_have   = 1'b0;
                        m_waited = 0;
                    end else begin
                        m_busy = 1'b0;
                    end
                end
                m_armed = 1'b1;
            end
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Directed vectors with literal expectations
    initial begin
        rst = 1'b1; req = 1'b1; dest = 2'b00; mem_rdy = 1'b1; hold = 1'b0;
        datain = 8'h00; latch = 8'h00;

        // Reset with request pending, then single DB fetch
        smp(); chk("rst_outs0", outs, 8'h00);
        adv(); smp(); chk("rst_outs1", outs, 8'h00);
        adv(); rst = 1'b0;
        smp(); chk("post_release", outs, 8'h00);
        adv(); smp(); chk("db_ack", outs, 8'b0000_1000);
        adv(); req = 1'b0;
        smp(); chk("db_wa", outs, 8'b1000_0001);
        adv(); smp(); chk("db_drive", outs, 8'b0100_0101);
        adv(); smp(); chk("db_idle", outs, 8'h00);

        // PAIR fetch: ADL then ADH with latch contents
        adv(); req = 1'b1; dest = 2'b11; datain = 8'h52;
        smp(); chk("pair_ack", outs, 8'b0000_1000);
        adv(); req = 1'b0; dest = 2'b00;
        smp(); chk("pair_wa1", outs, 8'b1000_0001);
        adv(); datain = 8'h92;
        smp(); chk("pair_adl", outs, 8'b0010_0001); chk("pair_latch1", latch, 8'h52);
        adv(); smp(); chk("pair_wa2", outs, 8'b1000_0001);
        adv(); smp(); chk("pair_adh", outs, 8'b0001_0101); chk("pair_latch2", latch, 8'h92);
        adv(); smp(); chk("pair_idle", outs, 8'h00);

        // ADL fetch with three wait-states
        adv(); req = 1'b1; dest = 2'b01; mem_rdy = 1'b0;
        smp(); chk("ws_ack", outs, 8'b0000_1000);
        for (int i = 0; i < 3; i++) begin
            adv(); req = 1'b0;
            smp(); chk("ws_wait", outs, 8'b0000_0001);
        end
        adv(); mem_rdy = 1'b1;
        smp(); chk("ws_wa", outs, 8'b1000_0001);
        adv(); smp(); chk("ws_adl", outs, 8'b0010_0101);
        adv(); smp(); chk("ws_idle", outs, 8'h00);

        // Wait timeout: err on the 15th LOAD cycle
        adv(); req = 1'b1; dest = 2'b00; mem_rdy = 1'b0;
        smp(); chk("to_ack", outs, 8'b0000_1000);
        for (int i = 1; i <= WAIT_MAX; i++) begin
            adv(); req = 1'b0;
            smp();
            if (i < WAIT_MAX) chk("to_wait", outs, 8'b0000_0001);
            else              chk("to_err", outs, 8'b0000_0011);
        end
        adv(); smp(); chk("to_idle", outs, 8'h00);

        // ADH fetch with four hold cycles and a back-to-back DB request
        adv(); req = 1'b1; dest = 2'b10; mem_rdy = 1'b1;
        smp(); chk("hold_ack", outs, 8'b0000_1000);
        adv(); dest = 2'b00;
        smp(); chk("hold_wa", outs, 8'b1000_0001);
        adv(); hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp(); chk("hold_drive", outs, 8'b0001_0001);
            adv();
        end
        hold = 1'b0;
        smp(); chk("hold_done_ack", outs, 8'b0001_1101);
        adv(); req = 1'b0;
        smp(); chk("b2b_wa", outs, 8'b1000_0001);
        adv(); smp(); chk("b2b_db", outs, 8'b0100_0101);
        adv(); smp(); chk("b2b_idle", outs, 8'h00);

        // Reset during the ADL half of a pair
        adv(); req = 1'b1; dest = 2'b11;
        smp(); chk("ra_ack", outs, 8'b0000_1000);
        adv(); req = 1'b0;
        smp(); chk("ra_wa", outs, 8'b1000_0001);
        adv(); smp(); chk("ra_adl", outs, 8'b0010_0001);
        #1 rst = 1'b1;
        #1 chk("ra_async_drop", outs, 8'h00);
        adv(); smp(); chk("ra_in_rst", outs, 8'h00);
        adv(); rst = 1'b0;
        smp(); chk("ra_released", outs, 8'h00);
        for (int i = 0; i < 4; i++) begin
            adv(); smp(); chk("ra_quiet", outs, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_idl_sequencer
`default_nettype wire
